// File: rtl/mem_access_unit_if.sv
// Bundle between the MEM pipeline stage, the memory access unit and the
// single-port data memory. The unit sits on the slave side. The pipeline
// and memory model sit on the master side.
interface mem_access_if;
   logic        req_valid;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        stall;
   logic [31:0] dm_addr;
   logic [31:0] dm_din;
   logic        dm_we;
   logic [31:0] dm_dout;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        misalign;

   modport slave (
      input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, dm_dout,
      output stall, dm_addr, dm_din, dm_we, rsp_valid, rsp_rdata, misalign
   );

   modport master (
      output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, dm_dout,
      input  stall, dm_addr, dm_din, dm_we, rsp_valid, rsp_rdata, misalign
   );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit in front of a word-wide data memory.
// Loads and aligned word stores complete in a single cycle. Byte and
// halfword stores do a read-modify-write. The read and the lane merge
// happen in the accept cycle. The write happens in one extra RMW cycle,
// and the pipeline is stalled during that cycle.
module mem_access_unit #(
   parameter int ADDR_BITS = 10
) (
   input  logic         clk,
   input  logic         rst,
   mem_access_if.slave  bus
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RMW  = 1'b1
   } state_t;

   state_t                 state_r;
   logic [ADDR_BITS-1:0]   idx_r;
   logic [31:0]            merged_r;
   logic                   rsp_valid_r;
   logic [31:0]            rsp_rdata_r;
   logic                   misalign_r;

   logic                   bad_access_s;
   logic                   word_store_s;
   logic [ADDR_BITS-1:0]   req_idx_s;
   logic                   unused_addr_s;

   // Replace the addressed byte or halfword lane of a memory word with store data.
   function automatic logic [31:0] merge_lanes(
      input logic [31:0] word,
      input logic [31:0] wdata,
      input logic [1:0]  size,
      input logic [1:0]  off
   );
      logic [31:0] m;
      m = word;
      if (size == 2'b00) begin
         case (off)
            2'd0:    m[7:0]   = wdata[7:0];
            2'd1:    m[15:8]  = wdata[7:0];
            2'd2:    m[23:16] = wdata[7:0];
            2'd3:    m[31:24] = wdata[7:0];
            default: m        = word;
         endcase
      end else begin
         if (off[1]) begin
            m[31:16] = wdata[15:0];
         end else begin
            m[15:0]  = wdata[15:0];
         end
      end
      return m;
   endfunction

   // Pick the addressed lane of a memory word and sign/zero extend it to 32 bits.
   function automatic logic [31:0] load_extend(
      input logic [31:0] word,
      input logic [1:0]  size,
      input logic        sgn,
      input logic [1:0]  off
   );
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      case (off)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         2'd3:    b = word[31:24];
         default: b = 8'h00;
      endcase
      h = off[1] ? word[31:16] : word[15:0];
      case (size)
         2'b00:   r = {{24{sgn & b[7]}}, b};
         2'b01:   r = {{16{sgn & h[15]}}, h};
         default: r = word;
      endcase
      return r;
   endfunction

   assign req_idx_s     = bus.req_addr[ADDR_BITS+1:2];
   // Address bits above the memory size wrap around and are intentionally dropped.
   assign unused_addr_s = ^bus.req_addr[31:ADDR_BITS+2];

   // Classify the incoming request and drive the memory port. Reset overrides the write and the stall.
   always_comb begin
      bad_access_s = 1'b0;
      word_store_s = 1'b0;
      bus.stall    = 1'b0;
      bus.dm_we    = 1'b0;
      bus.dm_addr  = {{(32-ADDR_BITS){1'b0}}, req_idx_s};
      bus.dm_din   = bus.req_wdata;

      case (bus.req_size)
         2'b00:   bad_access_s = 1'b0;
         2'b01:   bad_access_s = bus.req_addr[0];
         2'b10:   bad_access_s = (bus.req_addr[1:0] != 2'b00);
         default: bad_access_s = 1'b1;
      endcase

      word_store_s = bus.req_valid && bus.req_we &&
                     (bus.req_size == 2'b10) && !bad_access_s;

      if (rst) begin
         bus.stall = 1'b0;
         bus.dm_we = 1'b0;
      end else if (state_r == RMW) begin
         bus.stall   = 1'b1;
         bus.dm_we   = 1'b1;
         bus.dm_addr = {{(32-ADDR_BITS){1'b0}}, idx_r};
         bus.dm_din  = merged_r;
      end else begin
         bus.stall = 1'b0;
         bus.dm_we = word_store_s;
      end
   end

   // Access FSM plus the registered response, the misalign pulse and the sub-word store latch.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         idx_r       <= {ADDR_BITS{1'b0}};
         merged_r    <= 32'h0000_0000;
         rsp_valid_r <= 1'b0;
         rsp_rdata_r <= 32'h0000_0000;
         misalign_r  <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               rsp_valid_r <= 1'b0;
               rsp_rdata_r <= 32'h0000_0000;
               misalign_r  <= 1'b0;
               if (bus.req_valid) begin
                  if (bad_access_s) begin
                     rsp_valid_r <= 1'b1;
                     misalign_r  <= 1'b1;
                  end else if (bus.req_we) begin
                     if (bus.req_size == 2'b10) begin
                        rsp_valid_r <= 1'b1;
                     end else begin
                        idx_r    <= req_idx_s;
                        merged_r <= merge_lanes(bus.dm_dout, bus.req_wdata,
                                                bus.req_size, bus.req_addr[1:0]);
                        state_r  <= RMW;
                     end
                  end else begin
                     rsp_valid_r <= 1'b1;
                     rsp_rdata_r <= load_extend(bus.dm_dout, bus.req_size,
                                                bus.req_signed, bus.req_addr[1:0]);
                  end
               end else begin
                  state_r <= IDLE;
               end
            end
            RMW: begin
               state_r     <= IDLE;
               rsp_valid_r <= 1'b1;
               rsp_rdata_r <= 32'h0000_0000;
               misalign_r  <= 1'b0;
            end
            default: begin
               state_r     <= IDLE;
               rsp_valid_r <= 1'b0;
               rsp_rdata_r <= 32'h0000_0000;
               misalign_r  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.rsp_valid = rsp_valid_r;
   assign bus.rsp_rdata = rsp_rdata_r;
   assign bus.misalign  = misalign_r;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit against a transaction-level model
// of the data memory contents and the expected per-cycle response.
module tb_mem_access_unit;

   logic clk;
   logic rst;
   mem_access_if bus ();

   logic [31:0] mem     [0:1023];
   logic [31:0] ref_mem [0:1023];

   int n_tests;
   int n_fail;

   bit          m_busy;
   int          m_idx;
   logic [31:0] m_word;

   mem_access_unit #(.ADDR_BITS(10)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Data memory: combinational read, write on the rising edge.
   assign bus.dm_dout = mem[bus.dm_addr[9:0]];
   always @(posedge clk) begin
      if (bus.dm_we) mem[bus.dm_addr[9:0]] <= bus.dm_din;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock cycle. It drives the inputs, checks the memory port before the edge,
   // then checks the registered response after the edge.
   task automatic step(input bit r, input bit v, input bit we, input logic [1:0] sz,
                       input bit sg, input logic [31:0] a, input logic [31:0] wd);
      bit          exp_we, bad, ev, em;
      logic [31:0] ed, w, mask, lane;
      int          idx, sh;
      logic [1:0]  off;

      rst            = r;
      bus.req_valid  = v;
      bus.req_we     = we;
      bus.req_size   = sz;
      bus.req_signed = sg;
      bus.req_addr   = a;
      bus.req_wdata  = wd;
      #1;
      idx = int'(a[11:2]);
      off = a[1:0];
      sh  = 8 * int'(off);
      bad = (sz == 2'b11) || (sz == 2'b01 && off[0]) || (sz == 2'b10 && off != 2'b00);

      if (r) begin
         check("rst_dm_we", 32'(bus.dm_we), 32'd0);
         check("rst_stall", 32'(bus.stall), 32'd0);
      end else if (m_busy) begin
         check("rmw_stall", 32'(bus.stall), 32'd1);
         check("rmw_dm_we", 32'(bus.dm_we), 32'd1);
         check("rmw_dm_addr", bus.dm_addr, 32'(m_idx));
         check("rmw_dm_din", bus.dm_din, m_word);
      end else begin
         exp_we = v && we && (sz == 2'b10) && !bad;
         check("idle_stall", 32'(bus.stall), 32'd0);
         check("idle_dm_we", 32'(bus.dm_we), 32'(exp_we));
         if (exp_we) begin
            check("wst_dm_addr", bus.dm_addr, 32'(idx));
            check("wst_dm_din", bus.dm_din, wd);
         end
      end

      ev = 1'b0; ed = 32'd0; em = 1'b0;
      if (r) begin
         m_busy = 1'b0;
      end else if (m_busy) begin
         ref_mem[m_idx] = m_word;
         m_busy = 1'b0;
         ev = 1'b1;
      end else if (v) begin
         w = ref_mem[idx];
         if (bad) begin
            ev = 1'b1; em = 1'b1;
         end else if (we) begin
            if (sz == 2'b10) begin
               ref_mem[idx] = wd;
               ev = 1'b1;
            end else begin
               mask   = ((sz == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
               m_word = (w & ~mask) | ((wd << sh) & mask);
               m_idx  = idx;
               m_busy = 1'b1;
            end
         end else begin
            ev = 1'b1;
            if (sz == 2'b10) begin
               ed = w;
            end else if (sz == 2'b00) begin
               lane = (w >> sh) & 32'h0000_00FF;
               ed = (sg && lane[7]) ? (lane | 32'hFFFF_FF00) : lane;
            end else begin
               lane = (w >> sh) & 32'h0000_FFFF;
               ed = (sg && lane[15]) ? (lane | 32'hFFFF_0000) : lane;
            end
         end
      end

      @(posedge clk);
      #1;
      check("rsp_valid", 32'(bus.rsp_valid), 32'(ev));
      check("rsp_rdata", bus.rsp_rdata, ed);
      check("misalign", 32'(bus.misalign), 32'(em));
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
   endtask

   initial begin
      logic [31:0] a, d;
      n_tests = 0;
      n_fail  = 0;
      m_busy  = 1'b0;
      m_idx   = 0;
      m_word  = 32'd0;

      // Reset with a request present; it must be ignored.
      step(1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 32'h0000_0000, 32'hDEAD_BEEF);
      step(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0000_0000, 32'h0000_0000);
      idle();

      // Fill memory with word stores so that both memories agree.
      for (int i = 0; i < 1024; i++)
         step(1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 32'(i * 4), $urandom);

      // Byte loads with sign extension.
      step(1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 32'h10, 32'h1122_3344);
      step(1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 32'h11, 32'd0);
      step(1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 32'h13, 32'd0);
      step(1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 32'h10, 32'h1122_33F4);
      step(1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 32'h10, 32'd0);

      // Byte store read-modify-write, followed by a word load.
      step(1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 32'h10, 32'h1122_3344);
      step(1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 32'h12, 32'h0000_00AB);
      idle();
      step(1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'd0);

      // Halfword store, then signed and unsigned halfword loads.
      step(1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 32'h22, 32'h1234_BEEF);
      idle();
      step(1'b0, 1'b1, 1'b0, 2'b01, 1'b1, 32'h22, 32'd0);
      step(1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 32'h22, 32'd0);

      // Misaligned and reserved-size accesses.
      step(1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 32'h06, 32'hCAFE_F00D);
      step(1'b0, 1'b1, 1'b0, 2'b01, 1'b1, 32'h05, 32'd0);
      step(1'b0, 1'b1, 1'b1, 2'b11, 1'b0, 32'h08, 32'h5555_5555);

      // Reset landing in the RMW cycle drops the write.
      step(1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 32'h12, 32'h0000_0077);
      step(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
      step(1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'd0);

      // Alternating word store / load every cycle.
      for (int i = 0; i < 64; i++) begin
         step(1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 32'(i * 4), $urandom);
         step(1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 32'(i * 4), 32'd0);
      end

      // Random traffic. Addresses are often confined to a few words and high bits are random.
      for (int i = 0; i < 3000; i++) begin
         a = $urandom;
         if ($urandom_range(1) == 0) a[11:6] = 6'd0;
         d = $urandom;
         step($urandom_range(63) == 0, $urandom_range(3) != 0, 1'($urandom_range(1)),
              2'($urandom_range(3)), 1'($urandom_range(1)), a, d);
      end

      idle();
      idle();
      for (int i = 0; i < 1024; i++)
         check("mem_final", mem[i], ref_mem[i]);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter ADDR_BITS, default 10, word-index width driven to the data memory (1024 words).
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req_valid  input  1  MEM-stage access request present this cycle.
REQ-005 req_we  input  1  1 = store, 0 = load.
REQ-006 req_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved.
REQ-007 req_signed  input  1  loads only: 1 = sign-extend, 0 = zero-extend.
REQ-008 req_addr  input  32  byte address from EX/MEM.
REQ-009 req_wdata  input  32  store data, right-justified (byte in [7:0], half in [15:0]).
REQ-010 stall  output  1  freeze upstream pipeline; request inputs ignored while high.
REQ-011 dm_addr  output  32  word index to data memory, {zeros, req_addr[ADDR_BITS+1:2]}.
REQ-012 dm_din  output  32  write word to data memory.
REQ-013 dm_we  output  1  write enable to data memory (memory writes on posedge clk).
REQ-014 dm_dout  input  32  combinational read word from data memory at dm_addr.
REQ-015 rsp_valid  output  1  registered: load result / access completion valid this cycle.
REQ-016 rsp_rdata  output  32  registered, extended load data to WB.
REQ-017 misalign  output  1  registered one-cycle pulse: accepted request was misaligned or reserved size.

Function
REQ-018 States: IDLE, RMW; stall = (state == RMW); dm_we = 0 in IDLE except for aligned word stores.
REQ-019 IDLE, no req_valid: dm_we=0, dm_addr from req_addr, next rsp_valid=0, misalign=0.
REQ-020 IDLE accept: request with req_valid=1 is consumed in the same cycle; upstream advances.
REQ-021 Misaligned: half with addr[0]=1, word with addr[1:0]!=0, or size 11 -> no write, next cycle misalign=1, rsp_valid=1, rsp_rdata=0.
REQ-022 Aligned word store: dm_we=1, dm_din=req_wdata same cycle; next cycle rsp_valid=1, rsp_rdata=0; state stays IDLE.
REQ-023 Byte/half store: in accept cycle dm_we=0; latch word index and merged word (dm_dout with target lane(s) from addr[1:0] replaced by req_wdata[7:0] or [15:0]); go to RMW.
REQ-024 RMW (exactly one cycle): dm_addr = latched index, dm_din = latched merged word, dm_we=1, stall=1; next state IDLE; rsp_valid=1 on the following cycle, rsp_rdata=0.
REQ-025 Lanes little-endian: byte n = bits [8n+7:8n] for addr[1:0]=n; half at addr[1]=h = bits [16h+15:16h].
REQ-026 Load: lane selected from dm_dout by addr[1:0], extended per req_signed to 32 bits, registered; rsp_valid=1 exactly one cycle after accept; word load ignores req_signed.
REQ-027 Back-to-back: accepted request every IDLE cycle; throughput 1/cycle for loads and word stores, 1 per 2 cycles for sub-word stores.
REQ-028 Store followed by load to same word: load issued after RMW returns the merged value.
REQ-029 Address bits above ADDR_BITS+1 ignored (wrap-around within memory).

Reset
REQ-030 rst=1 at posedge: state=IDLE, rsp_valid=0, rsp_rdata=0, misalign=0, latched index/word=0.
REQ-031 While rst=1: dm_we=0 and stall=0 combinationally, including a reset landing in RMW; the pending sub-word write is dropped.
REQ-032 Request presented in a reset cycle is not accepted and produces no response.

Verification
REQ-033 Memory word 4 = 0x11223344; load byte addr 0x11 signed=1 -> next cycle rsp_valid=1, rsp_rdata=0x00000033; addr 0x13 signed=1 -> 0x00000011; byte at addr 0x10 with word 0x112233F4 -> 0xFFFFFFF4.
REQ-034 Store byte 0xAB at addr 0x12 on word 0x11223344 -> stall=1 one cycle, dm_we=1 with dm_addr=4, dm_din=0x11AB3344; subsequent word load returns 0x11AB3344.
REQ-035 Store half 0xBEEF at addr 0x22 then load half signed at 0x22 -> rsp_rdata=0xFFFFBEEF; unsigned -> 0x0000BEEF.
REQ-036 Word store addr 0x06 or half load addr 0x05 -> dm_we never 1, next cycle misalign=1, rsp_valid=1, rsp_rdata=0.
REQ-037 Assert rst during RMW cycle of a byte store -> dm_we=0, stall=0, memory word unchanged, next cycle state IDLE with rsp_valid=0.
REQ-038 Alternating word stores and loads every cycle to addrs 0x0..0xFC -> stall never high, each load returns last stored value one cycle after accept.
